// File: rtl/ysyx_22040237_idu_pipe.sv
// rtl/ysyx_22040237_idu_pipe.sv - pipelined RV64I decode stage between IFU and EXU (optional word ops: YSYX_22040237_IDU_RV64W_EN)
module ysyx_22040237_idu_pipe #(
  parameter int XLEN = 64,
  parameter int OPW  = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_rs1_r_en,
  output logic            o_rs2_r_en,
  output logic [4:0]      o_rs1_r_addr,
  output logic [4:0]      o_rs2_r_addr,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [OPW-1:0]  o_inst_opcode,
  output logic [XLEN-1:0] o_op1,
  output logic [XLEN-1:0] o_op2,
  output logic            o_rd_w_en,
  output logic [4:0]      o_rd_w_addr,
  output logic            o_illegal
);

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] F7_BASE      = 7'b0000000;
  localparam logic [6:0] F7_ALT       = 7'b0100000;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [OPW-1:0]  w_uop;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic            w_ill;
  logic            w_rs1_use;
  logic            w_rs2_use;
  logic            w_fire_in;

  assign w_opcode = i_inst[6:0];
  assign w_funct3 = i_inst[14:12];
  assign w_funct7 = i_inst[31:25];
  assign w_rd     = i_inst[11:7];
  assign w_imm_i  = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
  assign w_imm_u  = {{(XLEN-32){i_inst[31]}}, i_inst[31:12], 12'b0};

  // Decode the instruction word into micro-op code, operands and legality
  always_comb begin
    w_uop     = '0;
    w_op1     = '0;
    w_op2     = '0;
    w_ill     = 1'b1;
    w_rs1_use = 1'b0;
    w_rs2_use = 1'b0;
    case (w_opcode)
      OPC_OP_IMM: begin
        w_rs1_use = 1'b1;
        w_op1     = i_rs1_data;
        w_op2     = w_imm_i;
        w_ill     = 1'b0;
        case (w_funct3)
          3'b000:  w_uop = OPW'(8'h11);
          3'b010:  w_uop = OPW'(8'h12);
          3'b100:  w_uop = OPW'(8'h13);
          3'b110:  w_uop = OPW'(8'h14);
          3'b111:  w_uop = OPW'(8'h15);
          default: w_ill = 1'b1;
        endcase
      end
      OPC_OP: begin
        w_rs1_use = 1'b1;
        w_rs2_use = 1'b1;
        w_op1     = i_rs1_data;
        w_op2     = i_rs2_data;
        w_ill     = 1'b0;
        if (w_funct7 == F7_BASE) begin
          case (w_funct3)
            3'b000:  w_uop = OPW'(8'h21);
            3'b010:  w_uop = OPW'(8'h23);
            3'b100:  w_uop = OPW'(8'h24);
            3'b110:  w_uop = OPW'(8'h25);
            3'b111:  w_uop = OPW'(8'h26);
            default: w_ill = 1'b1;
          endcase
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
          w_uop = OPW'(8'h22);
        end else begin
          w_ill = 1'b1;
        end
      end
      OPC_LUI: begin
        w_uop = OPW'(8'h31);
        w_op2 = w_imm_u;
        w_ill = 1'b0;
      end
      OPC_AUIPC: begin
        w_uop = OPW'(8'h32);
        w_op1 = i_pc;
        w_op2 = w_imm_u;
        w_ill = 1'b0;
      end
`ifdef YSYX_22040237_IDU_RV64W_EN
      OPC_OP_IMM32: begin
        w_rs1_use = 1'b1;
        w_op1     = i_rs1_data;
        w_op2     = w_imm_i;
        if (w_funct3 == 3'b000) begin
          w_uop = OPW'(8'h41);
          w_ill = 1'b0;
        end
      end
      OPC_OP32: begin
        w_rs1_use = 1'b1;
        w_rs2_use = 1'b1;
        w_op1     = i_rs1_data;
        w_op2     = i_rs2_data;
        if (w_funct3 == 3'b000 && w_funct7 == F7_BASE) begin
          w_uop = OPW'(8'h42);
          w_ill = 1'b0;
        end else if (w_funct3 == 3'b000 && w_funct7 == F7_ALT) begin
          w_uop = OPW'(8'h43);
          w_ill = 1'b0;
        end
      end
`else
      OPC_OP_IMM32, OPC_OP32: w_ill = 1'b1;
`endif
      default: w_ill = 1'b1;
    endcase
    // An undecodable word carries no payload downstream
    if (w_ill) begin
      w_uop = '0;
      w_op1 = '0;
      w_op2 = '0;
    end
  end

  assign o_in_ready   = ~o_out_valid | i_out_ready;
  assign w_fire_in    = i_in_valid & o_in_ready;
  assign o_rs1_r_en   = i_in_valid & w_rs1_use;
  assign o_rs2_r_en   = i_in_valid & w_rs2_use;
  assign o_rs1_r_addr = o_rs1_r_en ? i_inst[19:15] : 5'd0;
  assign o_rs2_r_addr = o_rs2_r_en ? i_inst[24:20] : 5'd0;

  // Valid flag: flush kills, capture sets, consumption clears
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_out_valid <= 1'b0;
    end else if (i_flush) begin
      o_out_valid <= 1'b0;
    end else if (w_fire_in) begin
      o_out_valid <= 1'b1;
    end else if (i_out_ready) begin
      o_out_valid <= 1'b0;
    end
  end

  // Payload register loads only on an accepted, non-flushed word
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_inst_opcode <= '0;
      o_op1         <= '0;
      o_op2         <= '0;
      o_rd_w_en     <= 1'b0;
      o_rd_w_addr   <= 5'd0;
      o_illegal     <= 1'b0;
    end else if (w_fire_in && !i_flush) begin
      o_inst_opcode <= w_uop;
      o_op1         <= w_op1;
      o_op2         <= w_op2;
      o_rd_w_en     <= ~w_ill & (w_rd != 5'd0);
      o_rd_w_addr   <= w_ill ? 5'd0 : w_rd;
      o_illegal     <= w_ill;
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_idu_pipe.sv
// tb/tb_ysyx_22040237_idu_pipe.sv - directed scoreboard bench for the decode stage
module tb_ysyx_22040237_idu_pipe;

  typedef struct {
    logic [7:0]  op;
    logic [63:0] op1;
    logic [63:0] op2;
    logic        rdw;
    logic [4:0]  rda;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        rs1_r_en, rs2_r_en;
  logic [4:0]  rs1_r_addr, rs2_r_addr;
  logic [63:0] rs1_data, rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  inst_opcode;
  logic [63:0] op1, op2;
  logic        rd_w_en;
  logic [4:0]  rd_w_addr;
  logic        illegal;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  logic m_valid  = 1'b0;
  exp_t e_ill;
  exp_t e_w;

  ysyx_22040237_idu_pipe #(.XLEN(64), .OPW(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_inst(inst), .i_pc(pc),
    .o_rs1_r_en(rs1_r_en), .o_rs2_r_en(rs2_r_en),
    .o_rs1_r_addr(rs1_r_addr), .o_rs2_r_addr(rs2_r_addr),
    .i_rs1_data(rs1_data), .i_rs2_data(rs2_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_inst_opcode(inst_opcode), .o_op1(op1), .o_op2(op2),
    .o_rd_w_en(rd_w_en), .o_rd_w_addr(rd_w_addr), .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic rdw, input logic [4:0] rda, input logic ill);
    exp_t e;
    e.op = op; e.op1 = a; e.op2 = b; e.rdw = rdw; e.rda = rda; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check combinational outputs, clock, update model, check held micro-op
  task automatic step(input logic v, input logic [31:0] w, input logic [63:0] p,
                      input logic [63:0] r1, input logic [63:0] r2,
                      input logic ordy, input logic fl,
                      input logic [4:0] ea1, input logic [4:0] ea2, input exp_t e);
    logic exp_ir;
    logic fire;
    in_valid = v; inst = w; pc = p; rs1_data = r1; rs2_data = r2;
    out_ready = ordy; flush = fl;
    #3;
    exp_ir = ~m_valid | ordy;
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
    chk("rs1_r_addr", {59'd0, rs1_r_addr}, {59'd0, ea1});
    chk("rs2_r_addr", {59'd0, rs2_r_addr}, {59'd0, ea2});
    fire = v & exp_ir;
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_valid = 1'b0;
    end else begin
      if (m_valid && ordy) void'(q.pop_front());
      if (fire) q.push_back(e);
      m_valid = fire | (m_valid & ~ordy);
    end
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    if (m_valid && out_valid) begin
      if (q.size() == 0) begin
        chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        chk("inst_opcode", {56'd0, inst_opcode}, {56'd0, q[0].op});
        chk("illegal", {63'd0, illegal}, {63'd0, q[0].ill});
        chk("rd_w_en", {63'd0, rd_w_en}, {63'd0, q[0].rdw});
        chk("op1", op1, q[0].op1);
        chk("op2", op2, q[0].op2);
        if (!q[0].ill) chk("rd_w_addr", {59'd0, rd_w_addr}, {59'd0, q[0].rda});
      end
    end
  endtask

  initial begin
    e_ill = mk(8'h00, 64'd0, 64'd0, 1'b0, 5'd0, 1'b1);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; inst = 32'd0; pc = 64'd0;
    rs1_data = 64'd0; rs2_data = 64'd0; out_ready = 1'b1;
    #16;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_opcode", {56'd0, inst_opcode}, 64'd0);
    chk("rst_op2", op2, 64'd0);
    chk("rst_rd_w_en", {63'd0, rd_w_en}, 64'd0);
    chk("rst_illegal", {63'd0, illegal}, 64'd0);
    rst = 1'b0;

    // Back-to-back legal and illegal words
    step(1, 32'h00500093, 64'h0, 64'd0, 64'd0, 1, 0, 5'd0, 5'd0, mk(8'h11, 64'd0, 64'd5, 1, 5'd1, 0));
    step(1, 32'hFFF00113, 64'h0, 64'd0, 64'd0, 1, 0, 5'd0, 5'd0, mk(8'h11, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 5'd2, 0));
    step(1, 32'h402081B3, 64'h0, 64'd9, 64'd4, 1, 0, 5'd1, 5'd2, mk(8'h22, 64'd9, 64'd4, 1, 5'd3, 0));
    step(1, 32'h12345297, 64'h8000_0000, 64'd7, 64'd7, 1, 0, 5'd0, 5'd0, mk(8'h32, 64'h8000_0000, 64'h1234_5000, 1, 5'd5, 0));
    step(1, 32'hABCDE0B7, 64'h40, 64'd7, 64'd7, 1, 0, 5'd0, 5'd0, mk(8'h31, 64'd0, 64'hFFFF_FFFF_ABCD_E000, 1, 5'd1, 0));
    step(1, 32'h00208033, 64'h0, 64'd3, 64'd6, 1, 0, 5'd1, 5'd2, mk(8'h21, 64'd3, 64'd6, 0, 5'd0, 0));
    step(1, 32'h00109093, 64'h0, 64'd3, 64'd6, 1, 0, 5'd1, 5'd0, e_ill);
    step(1, 32'h02208033, 64'h0, 64'd3, 64'd6, 1, 0, 5'd1, 5'd2, e_ill);
    step(1, 32'hFFFFFFFF, 64'h0, 64'd3, 64'd6, 1, 0, 5'd0, 5'd0, e_ill);
`ifdef YSYX_22040237_IDU_RV64W_EN
    e_w = mk(8'h41, 64'd10, 64'd5, 1, 5'd1, 0);
    step(1, 32'h0050809B, 64'h0, 64'd10, 64'd0, 1, 0, 5'd1, 5'd0, e_w);
`else
    e_w = e_ill;
    step(1, 32'h0050809B, 64'h0, 64'd10, 64'd0, 1, 0, 5'd0, 5'd0, e_w);
`endif
    step(0, 32'h00500093, 64'h0, 64'd0, 64'd0, 1, 0, 5'd0, 5'd0, e_ill);

    // Stall for 3 cycles, then flush with a word presented
    step(1, 32'h00500093, 64'h0, 64'd0, 64'd0, 1, 0, 5'd0, 5'd0, mk(8'h11, 64'd0, 64'd5, 1, 5'd1, 0));
    for (int i = 0; i < 3; i++)
      step(1, 32'h402081B3, 64'h0, 64'd9, 64'd4, 0, 0, 5'd1, 5'd2, e_ill);
    step(1, 32'h402081B3, 64'h0, 64'd9, 64'd4, 0, 1, 5'd1, 5'd2, e_ill);
    step(0, 32'h0, 64'h0, 64'd0, 64'd0, 1, 0, 5'd0, 5'd0, e_ill);

    // Flush wins over a same-cycle capture
    step(1, 32'h00500093, 64'h0, 64'd0, 64'd0, 1, 0, 5'd0, 5'd0, mk(8'h11, 64'd0, 64'd5, 1, 5'd1, 0));
    step(1, 32'hFFF00113, 64'h0, 64'd0, 64'd0, 1, 1, 5'd0, 5'd0, e_ill);
    step(0, 32'h0, 64'h0, 64'd0, 64'd0, 1, 0, 5'd0, 5'd0, e_ill);

    // Asynchronous reset in the middle of a stall
    step(1, 32'h12345297, 64'h8000_0000, 64'd0, 64'd0, 1, 0, 5'd0, 5'd0, mk(8'h32, 64'h8000_0000, 64'h1234_5000, 1, 5'd5, 0));
    step(1, 32'h00500093, 64'h0, 64'd0, 64'd0, 0, 0, 5'd0, 5'd0, e_ill);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_opcode", {56'd0, inst_opcode}, 64'd0);
    chk("arst_op1", op1, 64'd0);
    chk("arst_rd_w_addr", {59'd0, rd_w_addr}, 64'd0);
    rst = 1'b0;
    q.delete();
    m_valid = 1'b0;
    @(posedge clk);
    #1;
    step(1, 32'hFFF00113, 64'h0, 64'd0, 64'd0, 1, 0, 5'd0, 5'd0, mk(8'h11, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 5'd2, 0));
    step(0, 32'h0, 64'h0, 64'd0, 64'd0, 1, 0, 5'd0, 5'd0, e_ill);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
